// File: rtl/bam_pkg.sv
// Shared types and helpers for the BAM8 error monitor.
// Operand widths, FSM states and saturating arithmetic.
package bam_pkg;

    localparam int BAM_W  = 8;
    localparam int BAM_PW = 2 * BAM_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Unsigned add clamped to 2^width - 1 (width 1..64).
    function automatic logic [63:0] sat_add(
        input logic [63:0] acc,
        input logic [63:0] inc,
        input int unsigned width
    );
        logic [63:0] lim;
        logic [64:0] s;
        lim = (64'd1 << width) - 64'd1;
        s   = {1'b0, acc} + {1'b0, inc};
        if (s > {1'b0, lim}) begin
            return lim;
        end
        return s[63:0];
    endfunction

endpackage

// File: rtl/bam_err_pipe.sv
// Two-stage exact-product / absolute-difference pipeline.
// Stage 1 forms a*b, stage 2 forms |exact - approx|.
module bam_err_pipe
    import bam_pkg::*;
#(
    parameter int W = BAM_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           accept,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [2*W-1:0] approx,
    output logic           v1,
    output logic           v2,
    output logic [2*W-1:0] diff,
    output logic [W-1:0]   a2,
    output logic [W-1:0]   b2
);

    logic [2*W-1:0] exact1;
    logic [2*W-1:0] approx1;
    logic [W-1:0]   a1;
    logic [W-1:0]   b1;

    // Valid bits follow the sample through both stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= accept;
            v2 <= v1;
        end
    end

    // Stage 1: capture the sample and its exact product.
    always_ff @(posedge clk) begin
        if (accept) begin
            exact1  <= {{W{1'b0}}, a} * {{W{1'b0}}, b};
            approx1 <= approx;
            a1      <= a;
            b1      <= b;
        end
    end

    // Stage 2: magnitude of the error, either sign.
    always_ff @(posedge clk) begin
        if (v1) begin
            if (exact1 >= approx1) begin
                diff <= exact1 - approx1;
            end else begin
                diff <= approx1 - exact1;
            end
            a2 <= a1;
            b2 <= b1;
        end
    end

endmodule

// File: rtl/bam8_err_monitor.sv
// Run-based error statistics for the BAM8 multiplier.
// FSM sequences runs; accumulators fold in stage-2 results.
module bam8_err_monitor
    import bam_pkg::*;
#(
    parameter int W     = BAM_W,
    parameter int CNT_W = 16,
    parameter int SUM_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [2*W-1:0]   approx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_count,
    output logic [SUM_W-1:0] sum_abs_err,
    output logic [2*W-1:0]   max_abs_err,
    output logic [W-1:0]     max_a,
    output logic [W-1:0]     max_b
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] remaining;
    logic             accept;
    logic             start_ok;
    logic             v1;
    logic             v2;
    logic [2*W-1:0]   diff;
    logic [W-1:0]     a2;
    logic [W-1:0]     b2;

    assign accept   = in_valid & in_ready;
    assign start_ok = start & ((state == IDLE) | (state == DONE));

    bam_err_pipe #(
        .W(W)
    ) u_pipe (
        .clk    (clk),
        .rst    (rst),
        .accept (accept),
        .a      (a),
        .b      (b),
        .approx (approx),
        .v1     (v1),
        .v2     (v2),
        .diff   (diff),
        .a2     (a2),
        .b2     (b2)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; an empty run goes straight to DRAIN.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = (num_samples == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (accept && remaining == CNT_W'(1)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!v1 && !v2) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the state.
    always_comb begin
        in_ready = (state == RUN);
        busy     = (state == RUN) | (state == DRAIN);
        done     = (state == DONE);
    end

    // Samples left in the current run; never wraps below zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
        end else if (start_ok) begin
            remaining <= num_samples;
        end else if (accept && remaining != '0) begin
            remaining <= remaining - CNT_W'(1);
        end
    end

    // Statistics: cleared on run start, updated per stage-2 result.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            err_count   <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
            max_a       <= '0;
            max_b       <= '0;
        end else if (v2) begin
            sum_abs_err <= SUM_W'(sat_add(64'(sum_abs_err), 64'(diff), SUM_W));
            if (diff != '0 && err_count != '1) begin
                err_count <= err_count + CNT_W'(1);
            end
            if (diff > max_abs_err) begin
                max_abs_err <= diff;
                max_a       <= a2;
                max_b       <= b2;
            end
        end
    end

endmodule

// File: tb/tb_bam8_err_monitor.sv
// Self-checking bench for bam8_err_monitor.
// Two instances (32- and 16-bit sums) share all stimulus.
module tb_bam8_err_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_samples;
    logic        in_valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] approx;

    logic        in_ready, busy, done;
    logic [15:0] err_count, max_abs_err;
    logic [31:0] sum_abs_err;
    logic [7:0]  max_a, max_b;

    logic        s_in_ready, s_busy, s_done;
    logic [15:0] s_err_count, s_max_abs_err;
    logic [15:0] s_sum_abs_err;
    logic [7:0]  s_max_a, s_max_b;

    int errors = 0;
    int checks = 0;

    int qa[$];
    int qb[$];
    int qp[$];

    always #5 clk = ~clk;

    bam8_err_monitor dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .approx(approx), .busy(busy), .done(done), .err_count(err_count),
        .sum_abs_err(sum_abs_err), .max_abs_err(max_abs_err),
        .max_a(max_a), .max_b(max_b)
    );

    bam8_err_monitor #(.SUM_W(16)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(s_in_ready), .a(a), .b(b),
        .approx(approx), .busy(s_busy), .done(s_done),
        .err_count(s_err_count), .sum_abs_err(s_sum_abs_err),
        .max_abs_err(s_max_abs_err), .max_a(s_max_a), .max_b(s_max_b)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_stats(input string tag, input longint cnt,
                             input longint sum, input longint mx,
                             input longint ma, input longint mb);
        longint s32, s16;
        s32 = (sum > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : sum;
        s16 = (sum > 65535) ? 65535 : sum;
        chk({tag, ".err_count"}, err_count, cnt);
        chk({tag, ".sum"}, sum_abs_err, s32);
        chk({tag, ".max"}, max_abs_err, mx);
        chk({tag, ".max_a"}, max_a, ma);
        chk({tag, ".max_b"}, max_b, mb);
        chk({tag, ".sat_sum"}, s_sum_abs_err, s16);
        chk({tag, ".sat_cnt"}, s_err_count, cnt);
        chk({tag, ".sat_max"}, s_max_abs_err, mx);
    endtask

    task automatic push(input int pa, input int pb, input int pp);
        qa.push_back(pa);
        qb.push_back(pb);
        qp.push_back(pp);
    endtask

    // Reference: statistics straight from the sample list.
    task automatic model(output longint cnt, output longint sum,
                         output longint mx, output longint ma,
                         output longint mb);
        cnt = 0; sum = 0; mx = 0; ma = 0; mb = 0;
        foreach (qa[i]) begin
            longint ex, e;
            ex = longint'(qa[i]) * longint'(qb[i]);
            e  = (ex >= qp[i]) ? ex - qp[i] : qp[i] - ex;
            sum += e;
            if (e != 0) cnt++;
            if (e > mx) begin
                mx = e; ma = qa[i]; mb = qb[i];
            end
        end
    endtask

    // One complete run over the queued samples.
    task automatic do_run(input string tag, input int gap_pct,
                          input bit poke_start);
        int n, idx, guard, cyc;
        longint cnt, sum, mx, ma, mb;
        n = qa.size();
        @(negedge clk);
        start = 1'b1;
        num_samples = 16'(n);
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".busy0"}, busy, 1);
        chk({tag, ".rdy0"}, in_ready, (n > 0) ? 1 : 0);
        chk({tag, ".done0"}, done, 0);
        chk({tag, ".clr"}, sum_abs_err + err_count + max_abs_err, 0);
        idx = 0;
        guard = 0;
        while (idx < n && guard < 5000) begin
            in_valid = ($urandom_range(0, 99) >= gap_pct);
            a = 8'(qa[idx]);
            b = 8'(qb[idx]);
            approx = 16'(qp[idx]);
            if (poke_start) begin
                start = 1'b1;
                num_samples = 16'd3;
            end
            if (in_valid && in_ready) idx++;
            guard++;
            @(negedge clk);
        end
        start = 1'b0;
        in_valid = 1'b0;
        if (guard >= 5000) chk({tag, ".feed_timeout"}, idx, n);
        if (n > 0) begin
            chk({tag, ".drain_rdy"}, in_ready, 0);
            chk({tag, ".drain_busy"}, busy, 1);
            cyc = 1;
        end else begin
            cyc = 0;
        end
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, ".lat"}, cyc, (n > 0) ? 4 : 1);
        chk({tag, ".busy_end"}, busy, 0);
        model(cnt, sum, mx, ma, mb);
        chk_stats(tag, cnt, sum, mx, ma, mb);
        repeat (3) @(negedge clk);
        chk({tag, ".hold"}, sum_abs_err, (sum > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : sum);
        qa.delete(); qb.delete(); qp.delete();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        num_samples = '0;
        in_valid = 1'b0;
        a = '0; b = '0; approx = '0;
        repeat (2) @(negedge clk);
        chk("reset.rdy", in_ready, 0);
        chk("reset.busy", busy, 0);
        chk("reset.done", done, 0);
        chk_stats("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Reset in the middle of a run.
        @(negedge clk);
        start = 1'b1;
        num_samples = 16'd10;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = 8'd9; b = 8'd9; approx = 16'd1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst.busy", busy, 0);
        chk("midrst.done", done, 0);
        chk("midrst.rdy", in_ready, 0);
        chk_stats("midrst", 0, 0, 0, 0, 0);
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        chk("midrst.ignored_rdy", in_ready, 0);
        chk_stats("midrst.ignored", 0, 0, 0, 0, 0);

        // Single sample.
        push(3, 5, 0);
        do_run("single", 0, 0);
        chk_stats("single.fixed", 1, 15, 15, 3, 5);

        // Back-to-back directed.
        push(255, 255, 65024);
        push(16, 16, 256);
        push(200, 100, 19456);
        do_run("b2b", 0, 0);
        chk_stats("b2b.fixed", 2, 545, 544, 200, 100);

        // Tie and approx above exact.
        push(2, 2, 6);
        push(1, 4, 2);
        do_run("tie", 0, 0);
        chk_stats("tie.fixed", 2, 4, 2, 2, 2);

        // Empty run, then a short run.
        do_run("empty", 0, 0);
        push(7, 11, 70);
        push(12, 12, 144);
        do_run("after_empty", 0, 0);

        // Saturation of the 16-bit sum.
        push(255, 255, 0);
        push(255, 255, 0);
        do_run("sat", 0, 0);
        chk("sat.fixed16", s_sum_abs_err, 65535);
        chk("sat.fixed32", sum_abs_err, 130050);

        // Randomised runs, some with gaps and stray start pulses.
        for (int r = 0; r < 12; r++) begin
            int n;
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) begin
                int pa, pb, ex, pp;
                pa = $urandom_range(0, 255);
                pb = $urandom_range(0, 255);
                ex = pa * pb;
                case ($urandom_range(0, 3))
                    0: pp = ex;
                    1: pp = (ex > 300) ? ex - $urandom_range(0, 300) : 0;
                    2: pp = (ex < 65000) ? ex + $urandom_range(0, 500) : ex;
                    default: pp = $urandom_range(0, 65535);
                endcase
                push(pa, pb, pp);
            end
            do_run($sformatf("rnd%0d", r), (r % 3) * 30, (r % 4) == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bam8_err_monitor.md
# bam8_err_monitor

Streaming error-characterisation stage placed directly downstream of the 8-bit broken-array approximate multiplier. Each accepted sample carries the operands and the approximate product. The block computes the exact product and the absolute error, and accumulates run statistics over a programmed number of samples. Results are held for readout until the next run starts.

## Interface
Parameters:
- W, 8, operand width; products are 2W bits
- CNT_W, 16, sample-count width
- SUM_W, 32, error-sum accumulator width (≥ 2W)

Ports:
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run (honoured only in IDLE or DONE)
- num_samples  in  CNT_W  samples in the run; sampled on accepted start
- in_valid  in  1  sample present
- in_ready  out  1  block accepts sample this cycle
- a, b  in  W  operands fed to the multiplier
- approx  in  2W  approximate product from the multiplier
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE; results valid
- err_count  out  CNT_W  samples with approx ≠ exact
- sum_abs_err  out  SUM_W  Σ|exact − approx|, saturating
- max_abs_err  out  2W  largest |exact − approx|
- max_a, max_b  out  W  operands of the first sample reaching max_abs_err

## Operation
- FSM states and transitions:
  - IDLE: start → RUN, with all accumulators cleared and num_samples latched into remaining.
  - RUN: accept → remaining decremented. The accept that drives remaining to 0 moves the FSM to DRAIN.
  - DRAIN: once both pipeline valid bits are clear → DONE.
  - DONE: holds results; start → RUN, with accumulators cleared.
- num_samples = 0 at start → DRAIN (empty pipe) → DONE. Outputs are all zero.
- in_ready = (state == RUN).
- Accept = in_valid & in_ready. Samples arriving while in_ready = 0 are ignored; no backpressure storage.
- start in RUN or DRAIN is ignored.
- Stage 1 (on accept): register exact = a*b (2W bits, unsigned), approx, a, b, and v1.
- Stage 2: diff = |exact − approx| in 2W bits, handling either sign (BAM normally gives approx ≤ exact, but this is not relied on). Register diff, a, b, and v2.
- Accumulate when v2 is set:
  - sum_abs_err += diff, saturating at 2^SUM_W − 1.
  - err_count += (diff ≠ 0), saturating.
  - If diff > max_abs_err (strict), update max_abs_err, max_a and max_b; ties keep the earlier sample.
- rst (any state, including mid-run): state = IDLE, pipeline valid bits cleared, all outputs 0.

## Timing
- Reset values: in_ready = 0, busy = 0, done = 0, every statistic = 0.
- Accept at edge k: stage-1 registers update at edge k; stage-2 registers at k+1; accumulators at k+2.
- Full throughput: one sample per cycle, no bubbles required.
- Last accept at edge k: statistics final after edge k+2, and done = 1 from the cycle after edge k+3.
- start accepted at edge s: busy = 1 and in_ready = 1 from cycle s+1, done = 0 from cycle s+1, statistics read 0 from cycle s+1.
- Statistics are stable throughout DONE.
- remaining wraps never; it is only decremented while nonzero.

## Structure
- Shared package bam_pkg holds:
  - W and the product-width constant 2W;
  - the state enum {IDLE, RUN, DRAIN, DONE};
  - the saturating-add helper function.
- One natural sub-module: bam_err_pipe, the two-stage exact-product / absolute-difference pipeline with its valid bits. The FSM and accumulators live in the top.

## Test plan
- Reset mid-run: after 3 accepted samples, assert rst for 1 cycle → all outputs 0, state IDLE, and later samples are ignored until start.
- Single sample: num_samples = 1, a = 3, b = 5, approx = 0 → done after 4 cycles; sum_abs_err = 15, err_count = 1, max_abs_err = 15, max_a = 3, max_b = 5.
- Back-to-back run of 3 samples, one per cycle:
  - (255, 255, 65024): error 1;
  - (16, 16, 256): exact, error 0;
  - (200, 100, 19456): error 544.
  - Required: sum = 545, err_count = 2, max = 544, max_a = 200, max_b = 100.
- Ties and approx > exact:
  - (2, 2, 6): error 2;
  - (1, 4, 2): error 2.
  - Required: max_a = 2, max_b = 2 (first sample kept); sum = 4.
- num_samples = 0 → done within 3 cycles, all statistics 0, in_ready never asserted. Then start with num_samples = 2: statistics cleared, new run completes normally.
- Saturation: instantiate with SUM_W = 16 and feed 2 samples of (255, 255, 0) → sum_abs_err = 65535, not a wrapped value.
